// File: rtl/pattern_pkg.sv
// -----------------------------------------------------------------------------
// pattern_pkg
// Shared definitions for the video test-pattern generator:
//   - mode_e     : pattern select encodings carried on MODE_I
//   - BAR_TABLE  : colour-bar table, one {R,G,B} full-scale flag triple per bar
//   - bar_flags  : lookup helper into BAR_TABLE
// -----------------------------------------------------------------------------
package pattern_pkg;

    typedef enum logic [2:0] {
        MODE_SOLID = 3'd0,
        MODE_BARS  = 3'd1,
        MODE_GRAD  = 3'd2,
        MODE_CHECK = 3'd3,
        MODE_LINE  = 3'd4
    } mode_e;

    // Entry i is bar i; each flag selects 0 or full scale for {R,G,B}.
    // Order left to right on screen: white, yellow, cyan, green,
    // magenta, red, blue, black.
    localparam logic [7:0][2:0] BAR_TABLE = {
        3'b000,   // 7 black
        3'b001,   // 6 blue
        3'b100,   // 5 red
        3'b101,   // 4 magenta
        3'b010,   // 3 green
        3'b011,   // 2 cyan
        3'b110,   // 1 yellow
        3'b111    // 0 white
    };

    function automatic logic [2:0] bar_flags(input logic [2:0] idx);
        return BAR_TABLE[idx];
    endfunction

endpackage

// File: rtl/pattern_pixel.sv
// -----------------------------------------------------------------------------
// pattern_pixel
// Combinational colour computation for one output pixel.
// Ports:
//   px        : horizontal pixel index of this port
//   py        : row index
//   mode      : latched pattern select
//   solid     : latched solid colour {R,G,B}
//   frame_cnt : frame counter used by the moving line
//   rgb       : resulting colour {R,G,B}, C_BPC bits per component
// -----------------------------------------------------------------------------
module pattern_pixel
    import pattern_pkg::*;
#(
    parameter int C_BPC      = 8,
    parameter int C_PX_W     = 14,
    parameter int C_CNT_W    = 12,
    parameter int C_BAR_LOG2 = 6,
    parameter int C_CHK_LOG2 = 5
) (
    input  logic [C_PX_W-1:0]  px,
    input  logic [C_CNT_W-1:0] py,
    input  logic [2:0]         mode,
    input  logic [3*C_BPC-1:0] solid,
    input  logic [15:0]        frame_cnt,
    output logic [3*C_BPC-1:0] rgb
);

    // Zero-extended copies so bit selects stay legal for any parameter set.
    logic [31:0] px_ext_s;
    logic [31:0] py_ext_s;
    logic [2:0]  bar_s;

    assign px_ext_s = 32'(px);
    assign py_ext_s = 32'(py);

    // Pattern colour selection for the latched mode.
    always_comb begin
        rgb   = '0;
        bar_s = bar_flags(px_ext_s[C_BAR_LOG2 +: 3]);
        case (mode_e'(mode))
            MODE_SOLID: rgb = solid;
            MODE_BARS:  rgb = {{C_BPC{bar_s[2]}}, {C_BPC{bar_s[1]}}, {C_BPC{bar_s[0]}}};
            MODE_GRAD:  rgb = {3{px_ext_s[C_BPC-1:0]}};
            MODE_CHECK: begin
                if ((px_ext_s[C_CHK_LOG2] ^ py_ext_s[C_CHK_LOG2]) == 1'b1) begin
                    rgb = '1;
                end else begin
                    rgb = '0;
                end
            end
            MODE_LINE: begin
                if (px_ext_s[11:0] == frame_cnt[11:0]) begin
                    rgb = '1;
                end else begin
                    rgb = '0;
                end
            end
            default: rgb = '0;
        endcase
    end

endmodule

// File: rtl/pattern_gen.sv
// -----------------------------------------------------------------------------
// pattern_gen
// Multi-pixel-per-clock video test-pattern generator driven by external timing.
// Ports:
//   CLK_I, RSTN_I          : clock, asynchronous active-low reset
//   VS_I, HS_I, DE_I       : input timing (active high)
//   MODE_I, SOLID_I        : pattern select and solid colour, latched at frame start
//   VS_O, HS_O, DE_O       : timing delayed by 2 cycles, replicated per port
//   R_O, G_O, B_O          : pixel data, port p at [p*C_BPC +: C_BPC], zero in blanking
//   FRAME_CNT_O            : 16-bit frame counter
// -----------------------------------------------------------------------------
module pattern_gen
    import pattern_pkg::*;
#(
    parameter int C_PORT_NUM = 4,
    parameter int C_BPC      = 8,
    parameter int C_CNT_W    = 12,
    parameter int C_BAR_LOG2 = 6,
    parameter int C_CHK_LOG2 = 5
) (
    input  logic                          CLK_I,
    input  logic                          RSTN_I,
    input  logic                          VS_I,
    input  logic                          HS_I,
    input  logic                          DE_I,
    input  logic [2:0]                    MODE_I,
    input  logic [3*C_BPC-1:0]            SOLID_I,
    output logic [C_PORT_NUM-1:0]         VS_O,
    output logic [C_PORT_NUM-1:0]         HS_O,
    output logic [C_PORT_NUM-1:0]         DE_O,
    output logic [C_PORT_NUM*C_BPC-1:0]   R_O,
    output logic [C_PORT_NUM*C_BPC-1:0]   G_O,
    output logic [C_PORT_NUM*C_BPC-1:0]   B_O,
    output logic [15:0]                   FRAME_CNT_O
);

    localparam int PX_W = C_CNT_W + $clog2(C_PORT_NUM) + 1;

    // Counter / latch state
    logic                 vs_prev_r;
    logic                 vs_armed_r;
    logic                 de_prev_r;
    logic [C_CNT_W-1:0]   x_r;
    logic [C_CNT_W-1:0]   y_r;
    logic [15:0]          frame_cnt_r;
    logic [2:0]           mode_r;
    logic [3*C_BPC-1:0]   solid_r;

    // Values seen by the current pixel and next-state values
    logic                 frame_start_s;
    logic [C_CNT_W-1:0]   x_cur_s;
    logic [C_CNT_W-1:0]   y_cur_s;
    logic [2:0]           mode_cur_s;
    logic [3*C_BPC-1:0]   solid_cur_s;
    logic [15:0]          fcnt_cur_s;
    logic [C_CNT_W-1:0]   x_next_s;
    logic [C_CNT_W-1:0]   y_next_s;

    // Pipeline stage 1
    logic                          vs1_r;
    logic                          hs1_r;
    logic                          de1_r;
    logic [C_PORT_NUM*C_BPC-1:0]   r1_r;
    logic [C_PORT_NUM*C_BPC-1:0]   g1_r;
    logic [C_PORT_NUM*C_BPC-1:0]   b1_r;

    logic [C_PORT_NUM*C_BPC-1:0]   r_s;
    logic [C_PORT_NUM*C_BPC-1:0]   g_s;
    logic [C_PORT_NUM*C_BPC-1:0]   b_s;

    // Frame-start detection and X/Y counter next-state.
    // vs_armed_r blocks a VS already high at reset release from counting:
    // it only becomes set after VS has been observed low.
    // On a frame-start cycle the current pixel already uses X=Y=0 and the
    // freshly presented mode/colour/count, so the first pixel is correct
    // even when VS and DE rise together.
    always_comb begin
        frame_start_s = VS_I & ~vs_prev_r & vs_armed_r;
        x_cur_s       = x_r;
        y_cur_s       = y_r;
        mode_cur_s    = mode_r;
        solid_cur_s   = solid_r;
        fcnt_cur_s    = frame_cnt_r;
        x_next_s      = x_r;
        y_next_s      = y_r;
        if (frame_start_s) begin
            x_cur_s     = '0;
            y_cur_s     = '0;
            mode_cur_s  = MODE_I;
            solid_cur_s = SOLID_I;
            fcnt_cur_s  = frame_cnt_r + 16'd1;
            if (DE_I) begin
                x_next_s = C_CNT_W'(1);
            end else begin
                x_next_s = '0;
            end
            y_next_s = '0;
        end else if (DE_I) begin
            x_next_s = x_r + C_CNT_W'(1);
        end else if (de_prev_r) begin
            x_next_s = '0;
            y_next_s = y_r + C_CNT_W'(1);
        end else begin
            x_next_s = x_r;
            y_next_s = y_r;
        end
    end

    // Counter, edge history and frame latch registers.
    always_ff @(posedge CLK_I or negedge RSTN_I) begin
        if (!RSTN_I) begin
            vs_prev_r   <= 1'b0;
            vs_armed_r  <= 1'b0;
            de_prev_r   <= 1'b0;
            x_r         <= '0;
            y_r         <= '0;
            frame_cnt_r <= 16'd0;
            mode_r      <= 3'd0;
            solid_r     <= '0;
        end else begin
            vs_prev_r   <= VS_I;
            vs_armed_r  <= vs_armed_r | ~VS_I;
            de_prev_r   <= DE_I;
            x_r         <= x_next_s;
            y_r         <= y_next_s;
            frame_cnt_r <= fcnt_cur_s;
            mode_r      <= mode_cur_s;
            solid_r     <= solid_cur_s;
        end
    end

    generate
        for (genvar p = 0; p < C_PORT_NUM; p++) begin : g_port
            logic [PX_W-1:0]      px_s;
            logic [3*C_BPC-1:0]   rgb_s;

            assign px_s = PX_W'(x_cur_s) * PX_W'(C_PORT_NUM) + PX_W'(p);

            pattern_pixel #(
                .C_BPC      (C_BPC),
                .C_PX_W     (PX_W),
                .C_CNT_W    (C_CNT_W),
                .C_BAR_LOG2 (C_BAR_LOG2),
                .C_CHK_LOG2 (C_CHK_LOG2)
            ) u_pixel (
                .px        (px_s),
                .py        (y_cur_s),
                .mode      (mode_cur_s),
                .solid     (solid_cur_s),
                .frame_cnt (fcnt_cur_s),
                .rgb       (rgb_s)
            );

            assign r_s[p*C_BPC +: C_BPC] = rgb_s[2*C_BPC +: C_BPC];
            assign g_s[p*C_BPC +: C_BPC] = rgb_s[C_BPC +: C_BPC];
            assign b_s[p*C_BPC +: C_BPC] = rgb_s[0 +: C_BPC];
        end
    endgenerate

    // Pipeline stage 1: capture timing and computed colours.
    always_ff @(posedge CLK_I or negedge RSTN_I) begin
        if (!RSTN_I) begin
            vs1_r <= 1'b0;
            hs1_r <= 1'b0;
            de1_r <= 1'b0;
            r1_r  <= '0;
            g1_r  <= '0;
            b1_r  <= '0;
        end else begin
            vs1_r <= VS_I;
            hs1_r <= HS_I;
            de1_r <= DE_I;
            r1_r  <= r_s;
            g1_r  <= g_s;
            b1_r  <= b_s;
        end
    end

    // Pipeline stage 2: replicate timing per port, blank data outside DE.
    always_ff @(posedge CLK_I or negedge RSTN_I) begin
        if (!RSTN_I) begin
            VS_O <= '0;
            HS_O <= '0;
            DE_O <= '0;
            R_O  <= '0;
            G_O  <= '0;
            B_O  <= '0;
        end else begin
            VS_O <= {C_PORT_NUM{vs1_r}};
            HS_O <= {C_PORT_NUM{hs1_r}};
            DE_O <= {C_PORT_NUM{de1_r}};
            if (de1_r) begin
                R_O <= r1_r;
                G_O <= g1_r;
                B_O <= b1_r;
            end else begin
                R_O <= '0;
                G_O <= '0;
                B_O <= '0;
            end
        end
    end

    assign FRAME_CNT_O = frame_cnt_r;

endmodule

// File: tb/tb_pattern_gen.sv
// -----------------------------------------------------------------------------
// tb_pattern_gen
// Directed bench for pattern_gen with default parameters. Every driven cycle
// pushes its expected output record onto a queue; the record is popped and
// compared once the 2-cycle pipeline delivers it.
// -----------------------------------------------------------------------------
module tb_pattern_gen;

    localparam int NP  = 4;
    localparam int BPC = 8;

    logic              CLK_I;
    logic              RSTN_I;
    logic              VS_I, HS_I, DE_I;
    logic [2:0]        MODE_I;
    logic [23:0]       SOLID_I;
    logic [NP-1:0]     VS_O, HS_O, DE_O;
    logic [NP*BPC-1:0] R_O, G_O, B_O;
    logic [15:0]       FRAME_CNT_O;

    typedef struct packed {
        logic        vs;
        logic        hs;
        logic        de;
        logic [31:0] r;
        logic [31:0] g;
        logic [31:0] b;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [2:0]  cur_mode;
    logic [23:0] cur_solid;
    logic [15:0] exp_fcnt;
    int          row;

    pattern_gen dut (
        .CLK_I       (CLK_I),
        .RSTN_I      (RSTN_I),
        .VS_I        (VS_I),
        .HS_I        (HS_I),
        .DE_I        (DE_I),
        .MODE_I      (MODE_I),
        .SOLID_I     (SOLID_I),
        .VS_O        (VS_O),
        .HS_O        (HS_O),
        .DE_O        (DE_O),
        .R_O         (R_O),
        .G_O         (G_O),
        .B_O         (B_O),
        .FRAME_CNT_O (FRAME_CNT_O)
    );

    initial CLK_I = 1'b0;
    always #5 CLK_I = ~CLK_I;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Reference colour for one pixel, written from the pattern definitions.
    function automatic logic [23:0] exp_pix(input logic [2:0] m, input int px, input int py,
                                            input logic [23:0] sol, input logic [15:0] fc);
        logic [7:0] v;
        case (m)
            3'd0: return sol;
            3'd1: begin
                case ((px / 64) % 8)
                    0: return 24'hFFFFFF;
                    1: return 24'hFFFF00;
                    2: return 24'h00FFFF;
                    3: return 24'h00FF00;
                    4: return 24'hFF00FF;
                    5: return 24'hFF0000;
                    6: return 24'h0000FF;
                    default: return 24'h000000;
                endcase
            end
            3'd2: begin
                v = 8'(px % 256);
                return {v, v, v};
            end
            3'd3: return ((((px / 32) % 2) ^ ((py / 32) % 2)) != 0) ? 24'hFFFFFF : 24'h000000;
            3'd4: return ((px % 4096) == (int'(fc) % 4096)) ? 24'hFFFFFF : 24'h000000;
            default: return 24'h000000;
        endcase
    endfunction

    // Drive one cycle, queue its expectation, compare the record now due.
    task automatic drive(input logic vs, input logic hs, input logic de, input logic [NP*24-1:0] rgb);
        exp_t e;
        exp_t d;
        e.vs = vs; e.hs = hs; e.de = de;
        e.r = '0; e.g = '0; e.b = '0;
        for (int p = 0; p < NP; p++) begin
            e.r[p*8 +: 8] = de ? rgb[p*24+16 +: 8] : 8'h00;
            e.g[p*8 +: 8] = de ? rgb[p*24+8  +: 8] : 8'h00;
            e.b[p*8 +: 8] = de ? rgb[p*24    +: 8] : 8'h00;
        end
        VS_I = vs; HS_I = hs; DE_I = de;
        exp_q.push_back(e);
        @(posedge CLK_I);
        #1;
        chk("frame_cnt", 32'(FRAME_CNT_O), 32'(exp_fcnt));
        if (exp_q.size() == 2) begin
            d = exp_q.pop_front();
            chk("vs_o", 32'(VS_O), 32'({NP{d.vs}}));
            chk("hs_o", 32'(HS_O), 32'({NP{d.hs}}));
            chk("de_o", 32'(DE_O), 32'({NP{d.de}}));
            chk("r_o", R_O, d.r);
            chk("g_o", G_O, d.g);
            chk("b_o", B_O, d.b);
        end
    endtask

    task automatic blank(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, (i == 1), 1'b0, '0);
    endtask

    task automatic frame_book();
        cur_mode  = MODE_I;
        cur_solid = SOLID_I;
        exp_fcnt  = exp_fcnt + 16'd1;
        row       = 0;
    endtask

    task automatic vstart();
        frame_book();
        drive(1'b1, 1'b0, 1'b0, '0);
        drive(1'b1, 1'b0, 1'b0, '0);
        drive(1'b0, 1'b0, 1'b0, '0);
        blank(2);
    endtask

    // One active line of n DE cycles; optionally VS rises on its first cycle.
    task automatic line(input int n, input bit with_vs);
        logic [NP*24-1:0] rgb;
        if (with_vs) frame_book();
        for (int i = 0; i < n; i++) begin
            for (int p = 0; p < NP; p++)
                rgb[p*24 +: 24] = exp_pix(cur_mode, i*NP + p, row, cur_solid, exp_fcnt);
            drive((with_vs && i == 0), 1'b0, 1'b1, rgb);
        end
        blank(3);
        row++;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_vs"}, 32'(VS_O), 32'd0);
        chk({tag, "_hs"}, 32'(HS_O), 32'd0);
        chk({tag, "_de"}, 32'(DE_O), 32'd0);
        chk({tag, "_r"}, R_O, 32'd0);
        chk({tag, "_g"}, G_O, 32'd0);
        chk({tag, "_b"}, B_O, 32'd0);
        chk({tag, "_fc"}, 32'(FRAME_CNT_O), 32'd0);
    endtask

    initial begin
        logic [NP*24-1:0] rgb;
        RSTN_I = 1'b0; VS_I = 1'b0; HS_I = 1'b0; DE_I = 1'b0;
        MODE_I = 3'd0; SOLID_I = 24'h0;
        cur_mode = 3'd0; cur_solid = 24'h0; exp_fcnt = 16'd0; row = 0;

        // Reset with random inputs; outputs must stay zero.
        for (int i = 0; i < 20; i++) begin
            VS_I = 1'($urandom); HS_I = 1'($urandom); DE_I = 1'($urandom);
            MODE_I = 3'($urandom); SOLID_I = 24'($urandom);
            @(posedge CLK_I);
            #1;
            chk_zero("reset");
        end
        VS_I = 1'b1; HS_I = 1'b0; DE_I = 1'b0; MODE_I = 3'd1; SOLID_I = 24'h0;
        @(posedge CLK_I);
        #1;
        RSTN_I = 1'b1;

        // VS already high at release must not count as frame start.
        drive(1'b1, 1'b0, 1'b0, '0);
        drive(1'b1, 1'b0, 1'b0, '0);
        drive(1'b1, 1'b0, 1'b0, '0);
        drive(1'b0, 1'b0, 1'b0, '0);
        blank(2);

        // Bars, then mode change mid-frame keeps bars.
        vstart();
        line(64, 1'b0);
        MODE_I = 3'd3;
        line(64, 1'b0);

        // Checker from the next frame; rows cross the PY bit-5 boundary.
        vstart();
        for (int l = 0; l < 36; l++) line(20, 1'b0);

        // Gradient wrap over 80 cycles.
        MODE_I = 3'd2;
        vstart();
        line(80, 1'b0);

        // Moving line.
        MODE_I = 3'd4;
        vstart();
        line(8, 1'b0);
        line(8, 1'b0);

        // Solid colour with horizontal and vertical blanking.
        MODE_I = 3'd0; SOLID_I = 24'h123456;
        vstart();
        line(16, 1'b0);
        line(16, 1'b0);
        blank(10);

        // Undefined modes give black.
        MODE_I = 3'd6;
        vstart();
        line(6, 1'b0);

        // VS and DE rising together: first pixel at X=0, then X=1.
        MODE_I = 3'd2;
        blank(2);
        line(16, 1'b1);
        line(16, 1'b0);

        // Reset asserted mid-line.
        for (int i = 0; i < 5; i++) begin
            for (int p = 0; p < NP; p++)
                rgb[p*24 +: 24] = exp_pix(cur_mode, i*NP + p, row, cur_solid, exp_fcnt);
            drive(1'b0, 1'b0, 1'b1, rgb);
        end
        RSTN_I = 1'b0;
        #1;
        exp_q.delete();
        cur_mode = 3'd0; cur_solid = 24'h0; exp_fcnt = 16'd0; row = 0;
        chk_zero("midline_rst");
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK_I);
            #1;
            chk_zero("midline_hold");
        end
        VS_I = 1'b0; DE_I = 1'b0;
        RSTN_I = 1'b1;
        // Latched mode/solid cleared: line without frame start is black.
        line(10, 1'b0);

        // Frame counter wrap: preload near the top, then two frame starts.
        force dut.frame_cnt_r = 16'hFFFE;
        #1;
        release dut.frame_cnt_r;
        exp_fcnt = 16'hFFFE;
        MODE_I = 3'd0; SOLID_I = 24'hABCDEF;
        vstart();
        vstart();
        line(4, 1'b0);
        blank(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
